// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Execute stage. Takes the decoder's 6-bit control code plus
//             rs1/rs2-or-immediate operands and the PC. Produces the ALU
//             result, the branch/jump decision and the redirect target.
//             Most codes complete in one cycle. Shifts by a non-zero amount
//             go through a 1-bit-per-cycle iterative shifter, and the
//             sequencer is told via busy/done.
//  Ports    : clk, rst_n (async, active low)
//             start, ctrl[5:0], op_a, op_b, pc    - request (start sampled when !busy)
//             busy                                - high while shifting
//             done                                - one-cycle result-valid pulse
//             result, branch_taken, target, illegal - held until next done
//  Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [5:0]      ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [XLEN-1:0] pc,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            branch_taken,
    output logic [XLEN-1:0] target,
    output logic            illegal
);

    // Operation codes
    localparam logic [5:0] c_add  = 6'd0,  c_sub  = 6'd1,  c_sll  = 6'd2,  c_slt   = 6'd3;
    localparam logic [5:0] c_sltu = 6'd4,  c_xor  = 6'd5,  c_srl  = 6'd6,  c_sra   = 6'd7;
    localparam logic [5:0] c_or   = 6'd8,  c_and  = 6'd9,  c_addi = 6'd10, c_slti  = 6'd11;
    localparam logic [5:0] c_sltiu= 6'd12, c_xori = 6'd13, c_ori  = 6'd14, c_andi  = 6'd15;
    localparam logic [5:0] c_slli = 6'd16, c_srli = 6'd17, c_srai = 6'd18;
    localparam logic [5:0] c_beq  = 6'd27, c_bne  = 6'd28, c_blt  = 6'd29, c_bge   = 6'd30;
    localparam logic [5:0] c_bltu = 6'd31, c_bgeu = 6'd32, c_lui  = 6'd33, c_auipc = 6'd34;
    localparam logic [5:0] c_jal  = 6'd35, c_jalr = 6'd36;

    // Shift direction / fill kinds held for the duration of an iterative shift
    localparam logic [1:0] c_kind_left = 2'd0;
    localparam logic [1:0] c_kind_srl  = 2'd1;
    localparam logic [1:0] c_kind_sra  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [XLEN-1:0]   target_q, target_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [XLEN-1:0]   work_q, work_d;
    logic [1:0]        kind_q, kind_d;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated directly on the live inputs; it is
    // only consumed on the accepting edge, which is what captures operands.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_sum, w_diff, w_pc_off, w_pc4;
    logic            w_lt, w_ltu, w_eq;
    logic [XLEN-1:0] w_res, w_tgt;
    logic            w_tk, w_ill;
    logic            w_is_shift;
    logic [1:0]      w_kind;
    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;

    assign w_sum    = op_a + op_b;
    assign w_diff   = op_a - op_b;
    assign w_pc_off = pc + op_b;
    assign w_pc4    = pc + XLEN'(4);
    assign w_lt     = $signed(op_a) < $signed(op_b);
    assign w_ltu    = op_a < op_b;
    assign w_eq     = op_a == op_b;
    assign w_shamt  = op_b[4:0];

    always_comb begin
        w_res = '0;
        w_tgt = '0;
        w_tk  = 1'b0;
        w_ill = 1'b0;
        case (ctrl)
            c_add, c_addi:   w_res = w_sum;
            c_sub:           w_res = w_diff;
            c_slt, c_slti:   w_res = {{(XLEN-1){1'b0}}, w_lt};
            c_sltu, c_sltiu: w_res = {{(XLEN-1){1'b0}}, w_ltu};
            c_xor, c_xori:   w_res = op_a ^ op_b;
            c_or, c_ori:     w_res = op_a | op_b;
            c_and, c_andi:   w_res = op_a & op_b;
            // Only reached with shamt==0; non-zero amounts use the shifter.
            c_sll, c_slli, c_srl, c_srli, c_sra, c_srai: w_res = op_a;
            // Loads and stores: effective address
            6'd19, 6'd20, 6'd21, 6'd22, 6'd23,
            6'd24, 6'd25, 6'd26: w_res = w_sum;
            c_beq, c_bne, c_blt, c_bge, c_bltu, c_bgeu: begin
                case (ctrl)
                    c_beq:   w_tk = w_eq;
                    c_bne:   w_tk = ~w_eq;
                    c_blt:   w_tk = w_lt;
                    c_bge:   w_tk = ~w_lt;
                    c_bltu:  w_tk = w_ltu;
                    default: w_tk = ~w_ltu;
                endcase
                w_res = {{(XLEN-1){1'b0}}, w_tk};
                w_tgt = w_pc_off;
            end
            c_lui:   w_res = op_b;
            c_auipc: w_res = w_pc_off;
            c_jal: begin
                w_res = w_pc4;
                w_tgt = w_pc_off;
                w_tk  = 1'b1;
            end
            c_jalr: begin
                w_res = w_pc4;
                w_tgt = {w_sum[XLEN-1:1], 1'b0};
                w_tk  = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
    end

    always_comb begin
        w_is_shift = 1'b1;
        w_kind     = c_kind_left;
        case (ctrl)
            c_sll, c_slli: w_kind = c_kind_left;
            c_srl, c_srli: w_kind = c_kind_srl;
            c_sra, c_srai: w_kind = c_kind_sra;
            default:       w_is_shift = 1'b0;
        endcase
    end

    // One-bit step of the iterative shifter
    always_comb begin
        case (kind_q)
            c_kind_srl: w_shifted = {1'b0, work_q[XLEN-1:1]};
            c_kind_sra: w_shifted = {work_q[XLEN-1], work_q[XLEN-1:1]};
            default:    w_shifted = {work_q[XLEN-2:0], 1'b0};
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        target_d  = target_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        kind_d    = kind_q;
        case (state_q)
            S_SHIFT: begin
                work_d = w_shifted;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d  = w_shifted;
                    target_d  = '0;
                    taken_d   = 1'b0;
                    illegal_d = 1'b0;
                    state_d   = S_DONE;
                end
            end
            default: begin // S_IDLE, S_DONE
                if (start) begin
                    if (w_is_shift && (w_shamt != 5'd0)) begin
                        work_d  = op_a;
                        cnt_d   = w_shamt;
                        kind_d  = w_kind;
                        state_d = S_SHIFT;
                    end else begin
                        result_d  = w_res;
                        target_d  = w_tgt;
                        taken_d   = w_tk;
                        illegal_d = w_ill;
                        state_d   = S_DONE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            target_q  <= '0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            work_q    <= '0;
            kind_q    <= c_kind_left;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            target_q  <= target_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            kind_q    <= kind_d;
        end
    end

    assign busy         = (state_q == S_SHIFT);
    assign done         = (state_q == S_DONE);
    assign result       = result_q;
    assign target       = target_q;
    assign branch_taken = taken_q;
    assign illegal      = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Self-checking bench for alu_exec_unit: vector table plus
//             hand-written multi-cycle sequences, expected results queued
//             at issue and compared when done is observed.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  ctrl = '0;
    logic [31:0] op_a = '0, op_b = '0, pc = '0;
    logic        busy, done, branch_taken, illegal;
    logic [31:0] result, target;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl),
        .op_a(op_a), .op_b(op_b), .pc(pc),
        .busy(busy), .done(done), .result(result),
        .branch_taken(branch_taken), .target(target), .illegal(illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [5:0]  c;
        logic [31:0] a, b, p;
        logic [31:0] res;
        logic        tk;
        logic [31:0] tgt;
        logic        ill;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        tk;
        logic [31:0] tgt;
        logic        ill;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[20];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic int exp_lat(logic [5:0] c, logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        if ((c == 6'd2 || c == 6'd6 || c == 6'd7 || c == 6'd16 || c == 6'd17 || c == 6'd18)
            && sh != 5'd0)
            return int'(sh) + 1;
        return 1;
    endfunction

    // Pop the oldest expectation and compare the held outputs against it.
    task automatic compare_out(int lat);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: done with no pending op, result %h", result);
        end else begin
            e = sb.pop_front();
            chk({e.name, ".result"},  result, e.res);
            chk({e.name, ".taken"},   32'(branch_taken), 32'(e.tk));
            chk({e.name, ".target"},  target, e.tgt);
            chk({e.name, ".illegal"}, 32'(illegal), 32'(e.ill));
            chk({e.name, ".latency"}, 32'(lat), 32'(e.lat));
        end
    endtask

    task automatic issue(vec_t v);
        exp_t e;
        ctrl = v.c; op_a = v.a; op_b = v.b; pc = v.p; start = 1'b1;
        e.res = v.res; e.tk = v.tk; e.tgt = v.tgt; e.ill = v.ill;
        e.lat = exp_lat(v.c, v.b); e.name = v.name;
        sb.push_back(e);
    endtask

    // Issue one op, scramble the inputs after acceptance, wait for done.
    task automatic run_op(vec_t v);
        int  lat;
        int  busy_cnt;
        bit  got;
        @(negedge clk);
        issue(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        op_a = $urandom; op_b = $urandom; pc = $urandom; ctrl = 6'($urandom);
        lat = 1; busy_cnt = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                compare_out(lat);
            end else begin
                if (busy) busy_cnt++;
                lat++;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: no done within 40 cycles, required done", v.name);
            void'(sb.pop_front());
        end else begin
            chk({v.name, ".busy_cycles"}, 32'(busy_cnt), 32'(lat - 1));
            @(negedge clk);
            chk({v.name, ".done_width"}, 32'(done), 32'd0);
        end
    endtask

    initial begin
        int   ndone;
        int   lat;
        bit   got;
        vec_t v;

        vecs[0]  = '{6'd0,  32'd5,        32'd7,        32'h0,    32'd12,       1'b0, 32'h0,        1'b0, "add"};
        vecs[1]  = '{6'd1,  32'd3,        32'd5,        32'h0,    32'hFFFFFFFE, 1'b0, 32'h0,        1'b0, "sub"};
        vecs[2]  = '{6'd4,  32'd1,        32'hFFFFFFFF, 32'h0,    32'd1,        1'b0, 32'h0,        1'b0, "sltu"};
        vecs[3]  = '{6'd3,  32'd1,        32'hFFFFFFFF, 32'h0,    32'd0,        1'b0, 32'h0,        1'b0, "slt"};
        vecs[4]  = '{6'd11, 32'hFFFFFFFB, 32'd3,        32'h0,    32'd1,        1'b0, 32'h0,        1'b0, "slti_neg"};
        vecs[5]  = '{6'd7,  32'h80000000, 32'd4,        32'h0,    32'hF8000000, 1'b0, 32'h0,        1'b0, "sra4"};
        vecs[6]  = '{6'd18, 32'h80000000, 32'd4,        32'h0,    32'hF8000000, 1'b0, 32'h0,        1'b0, "srai4"};
        vecs[7]  = '{6'd6,  32'h80000000, 32'd4,        32'h0,    32'h08000000, 1'b0, 32'h0,        1'b0, "srl4"};
        vecs[8]  = '{6'd2,  32'h00001234, 32'd0,        32'h0,    32'h00001234, 1'b0, 32'h0,        1'b0, "sll0"};
        vecs[9]  = '{6'd16, 32'h00000003, 32'd1,        32'h0,    32'h00000006, 1'b0, 32'h0,        1'b0, "slli1"};
        vecs[10] = '{6'd27, 32'h20,       32'h20,       32'h100,  32'd1,        1'b1, 32'h120,      1'b0, "beq"};
        vecs[11] = '{6'd30, 32'hFFFFFFFF, 32'd0,        32'h200,  32'd0,        1'b0, 32'h200,      1'b0, "bge"};
        vecs[12] = '{6'd31, 32'd1,        32'hFFFFFFFF, 32'h10,   32'd1,        1'b1, 32'hF,        1'b0, "bltu"};
        vecs[13] = '{6'd36, 32'h203,      32'd0,        32'h400,  32'h404,      1'b1, 32'h202,      1'b0, "jalr"};
        vecs[14] = '{6'd35, 32'h0,        32'h40,       32'h100,  32'h104,      1'b1, 32'h140,      1'b0, "jal"};
        vecs[15] = '{6'd33, 32'h5,        32'hABCDE000, 32'h0,    32'hABCDE000, 1'b0, 32'h0,        1'b0, "lui"};
        vecs[16] = '{6'd34, 32'h0,        32'h2000,     32'h1000, 32'h3000,     1'b0, 32'h0,        1'b0, "auipc"};
        vecs[17] = '{6'd19, 32'h100,      32'd4,        32'h0,    32'h104,      1'b0, 32'h0,        1'b0, "load"};
        vecs[18] = '{6'd13, 32'hF0F0,     32'hFF00,     32'h0,    32'h0FF0,     1'b0, 32'h0,        1'b0, "xori"};
        vecs[19] = '{6'd40, 32'h1,        32'h2,        32'h3,    32'h0,        1'b0, 32'h0,        1'b1, "illegal"};

        // Reset state and idle without start
        #12;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("idle.no_done", 32'(ndone), 32'd0);

        // Table-driven single ops
        foreach (vecs[i]) run_op(vecs[i]);

        // Back-to-back add then sub: done stays high two cycles
        @(negedge clk);
        issue(vecs[0]);
        @(posedge clk);
        #1;
        issue(vecs[1]);
        @(negedge clk);
        chk("b2b.done1", 32'(done), 32'd1);
        compare_out(1);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("b2b.done2", 32'(done), 32'd1);
        compare_out(1);
        @(negedge clk);
        chk("b2b.done3", 32'(done), 32'd0);
        chk("b2b.hold", result, 32'hFFFFFFFE);

        // Handshake abuse during a 31-cycle sll
        v = '{6'd2, 32'h3, 32'd31, 32'h0, 32'h80000000, 1'b0, 32'h0, 1'b0, "sll31_abuse"};
        @(negedge clk);
        issue(v);
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1; ndone = 0; got = 1'b0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 10) begin
                ctrl = 6'd0; op_a = 32'h0000FFFF; op_b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                ndone++;
                if (!got) compare_out(lat);
                got = 1'b1;
            end else if (!got) begin
                lat++;
            end
        end
        chk("abuse.done_count", 32'(ndone), 32'd1);

        // Reset in the middle of a shift
        @(negedge clk);
        ctrl = 6'd7; op_a = 32'h80000000; op_b = 32'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst.no_done", 32'(ndone), 32'd0);
        run_op(vecs[0]);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
